// File: rtl/quad_esc_pwm.sv
// quad_esc_pwm: drives four servo-style ESC pulse lines from four 11-bit motor speeds.
//
// A shared 17-bit frame counter runs 0..PERIOD-1. On the latch edge (cnt == PERIOD-1)
// the arm input and all four speeds are captured, and each applied speed is updated.
// Every pulse in the next frame then starts together with frm_strt in the cycle where
// cnt == 0. A pulse lasts MIN_PULSE + app*PULSE_SCALE cycles. Speed changes between
// latch edges do nothing until the next latch edge, so a pulse never changes width
// part-way through.
//
// Optional feature: define QUAD_ESC_SLEW_LIMIT_EN to limit how far each applied speed
// can move per armed frame (at most MAX_STEP). When it is not defined, the applied speed
// follows the captured target directly.
//
// Ports:
//   clk                                 system clock
//   rst                                 asynchronous, active-high reset
//   arm                                 1 = emit pulses; sampled at the latch edge
//   frnt_spd, bck_spd, lft_spd, rght_spd  unsigned 11-bit target speeds
//   frnt_pwm, bck_pwm, lft_pwm, rght_pwm  registered ESC pulse outputs
//   frm_strt                            registered one-cycle pulse in the first cycle of a frame
module quad_esc_pwm #(
  parameter int unsigned PERIOD      = 125000,
  parameter int unsigned MIN_PULSE   = 50000,
  parameter int unsigned PULSE_SCALE = 24,
  parameter int unsigned MAX_STEP    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frm_strt
);

  localparam logic [16:0] CntLast    = 17'(PERIOD - 1);
  localparam logic [16:0] MinPulse   = 17'(MIN_PULSE);
  localparam logic [16:0] PulseScale = 17'(PULSE_SCALE);

  // Move app toward tgt by at most MAX_STEP and clamp the result to 0..2047.
  function automatic logic [10:0] slew_toward(input logic [10:0] app, input logic [10:0] tgt);
    logic signed [11:0] diff;
    logic signed [12:0] nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, app});
    if (diff > $signed(12'(MAX_STEP))) begin
      nxt = $signed({2'b00, app}) + $signed(13'(MAX_STEP));
    end else if (diff < -$signed(12'(MAX_STEP))) begin
      nxt = $signed({2'b00, app}) - $signed(13'(MAX_STEP));
    end else begin
      nxt = $signed({2'b00, tgt});
    end
    if (nxt < 13'sd0) begin
      slew_toward = '0;
    end else if (nxt > 13'sd2047) begin
      slew_toward = 11'd2047;
    end else begin
      slew_toward = nxt[10:0];
    end
  endfunction

  logic [16:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        frm_strt_q, frm_strt_d;
  logic [3:0]  pwm_q, pwm_d;
  logic [10:0] app_q [4];
  logic [10:0] app_d [4];
  logic [10:0] spd   [4];
  logic [16:0] width [4];
  logic        latch;

  // Channel order: 0 = front, 1 = back, 2 = left, 3 = right.
  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  always_comb begin
    latch      = (cnt_q == CntLast);
    cnt_d      = latch ? '0 : cnt_q + 17'd1;
    armed_d    = latch ? arm : armed_q;
    frm_strt_d = latch;
    for (int i = 0; i < 4; i++) begin
      width[i] = MinPulse + 17'(app_q[i]) * PulseScale;
      app_d[i] = app_q[i];
      // A pulse only persists inside a frame that was armed at its latch edge.
      pwm_d[i] = pwm_q[i] & armed_q;
      if (cnt_q == width[i] - 17'd1) begin
        pwm_d[i] = 1'b0;
      end
      // Widths never reach PERIOD, so the pulse end cannot collide with the latch edge.
      if (latch) begin
        pwm_d[i] = arm;
        if (!arm) begin
          app_d[i] = '0;
        end else begin
`ifdef QUAD_ESC_SLEW_LIMIT_EN
          app_d[i] = slew_toward(app_q[i], spd[i]);
`else
          app_d[i] = spd[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      frm_strt_q <= 1'b0;
      pwm_q      <= '0;
      app_q      <= '{default: '0};
    end else begin
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      frm_strt_q <= frm_strt_d;
      pwm_q      <= pwm_d;
      app_q      <= app_d;
    end
  end

  assign frnt_pwm = pwm_q[0];
  assign bck_pwm  = pwm_q[1];
  assign lft_pwm  = pwm_q[2];
  assign rght_pwm = pwm_q[3];
  assign frm_strt = frm_strt_q;

endmodule
